// File: rtl/pusch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pusch_pkg
//  Brief    : Shared constants, FSM encoding and Gold-sequence step helpers
//             for the PUSCH bit scrambler.
//  Revision : 1.0  initial release
// ============================================================================
package pusch_pkg;

  localparam int NC       = 1600;  // Gold sequence offset before first output bit
  localparam int GOLD_LEN = 31;    // length of each m-sequence register

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  // One step of x1: x1(n+31) = x1(n+3) ^ x1(n); bit 0 holds x1(n)
  function automatic logic [GOLD_LEN-1:0] x1_step(input logic [GOLD_LEN-1:0] x);
    return {x[3] ^ x[0], x[GOLD_LEN-1:1]};
  endfunction

  // One step of x2: x2(n+31) = x2(n+3) ^ x2(n+2) ^ x2(n+1) ^ x2(n)
  function automatic logic [GOLD_LEN-1:0] x2_step(input logic [GOLD_LEN-1:0] x);
    return {x[3] ^ x[2] ^ x[1] ^ x[0], x[GOLD_LEN-1:1]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pusch_gold_gen.sv
`default_nettype none
// ============================================================================
//  Module   : pusch_gold_gen
//  Brief    : Length-31 Gold sequence generator. Loads x1=1, x2=seed, then
//             advances either N steps (warm-up) or 1 step (run) per cycle.
//  Revision : 1.0  initial release
// ============================================================================
module pusch_gold_gen
  import pusch_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [GOLD_LEN-1:0] seed,
  input  logic                step_multi,
  input  logic                step_one,
  output logic                c
);

  logic [GOLD_LEN-1:0] x1;
  logic [GOLD_LEN-1:0] x2;
  logic [GOLD_LEN-1:0] x1_chain [0:N];
  logic [GOLD_LEN-1:0] x2_chain [0:N];

  assign x1_chain[0] = x1;
  assign x2_chain[0] = x2;

  // Unrolled combinational chain: stage i+1 is stage i advanced by one step
  for (genvar i = 0; i < N; i++) begin : g_chain
    assign x1_chain[i+1] = x1_step(x1_chain[i]);
    assign x2_chain[i+1] = x2_step(x2_chain[i]);
  end

  assign c = x1[0] ^ x2[0];

  // Sequence registers: load has priority, otherwise take N or 1 steps, else hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x1 <= '0;
      x2 <= '0;
    end else if (load) begin
      x1 <= GOLD_LEN'(1);
      x2 <= seed;
    end else if (step_multi) begin
      x1 <= x1_chain[N];
      x2 <= x2_chain[N];
    end else if (step_one) begin
      x1 <= x1_chain[1];
      x2 <= x2_chain[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/pusch_scrambler.sv
`default_nettype none
// ============================================================================
//  Module   : pusch_scrambler
//  Brief    : Serial PUSCH bit scrambler, b~(i) = b(i) ^ c(i), with c(i) the
//             Gold sequence advanced NC steps past the c_init seed.
//  Revision : 1.0  initial release
// ============================================================================
module pusch_scrambler
  import pusch_pkg::*;
#(
  parameter int STEPS_PER_CYCLE = 8,
  parameter int E_WIDTH         = 17
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [GOLD_LEN-1:0] c_init,
  input  logic [E_WIDTH-1:0]  E,
  input  logic                data_in,
  input  logic                valid_in,
  output logic                data_out,
  output logic                valid_out,
  output logic                ready,
  output logic                done,
  output logic                err_drop
);

  localparam int WARM_CYCLES = NC / STEPS_PER_CYCLE;
  localparam int WARM_W      = (WARM_CYCLES > 1) ? $clog2(WARM_CYCLES) : 1;
  localparam logic [WARM_W-1:0]  WARM_LAST = WARM_W'(WARM_CYCLES - 1);
  localparam logic [E_WIDTH-1:0] E_ONE     = E_WIDTH'(1);

  state_t              state, state_nx;
  logic [WARM_W-1:0]   warm_cnt, warm_cnt_nx;
  logic [E_WIDTH-1:0]  bit_cnt, bit_cnt_nx;
  logic [E_WIDTH-1:0]  e_lat, e_lat_nx;
  logic                data_out_nx, valid_out_nx, done_nx, err_drop_nx;
  logic                load, step_multi, step_one;
  logic                c;

  pusch_gold_gen #(
    .N (STEPS_PER_CYCLE)
  ) u_gold (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .seed       (c_init),
    .step_multi (step_multi),
    .step_one   (step_one),
    .c          (c)
  );

  assign ready = (state == ST_RUN);

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      warm_cnt  <= '0;
      bit_cnt   <= '0;
      e_lat     <= '0;
      data_out  <= 1'b0;
      valid_out <= 1'b0;
      done      <= 1'b0;
      err_drop  <= 1'b0;
    end else begin
      state     <= state_nx;
      warm_cnt  <= warm_cnt_nx;
      bit_cnt   <= bit_cnt_nx;
      e_lat     <= e_lat_nx;
      data_out  <= data_out_nx;
      valid_out <= valid_out_nx;
      done      <= done_nx;
      err_drop  <= err_drop_nx;
    end
  end

  // Next-state and output logic; start overrides everything, including an in-flight bit
  always_comb begin
    state_nx     = state;
    warm_cnt_nx  = warm_cnt;
    bit_cnt_nx   = bit_cnt;
    e_lat_nx     = e_lat;
    data_out_nx  = data_out;
    valid_out_nx = 1'b0;
    done_nx      = 1'b0;
    err_drop_nx  = err_drop;
    load         = 1'b0;
    step_multi   = 1'b0;
    step_one     = 1'b0;

    if (start) begin
      load        = 1'b1;
      state_nx    = ST_WARMUP;
      e_lat_nx    = E;
      warm_cnt_nx = '0;
      bit_cnt_nx  = '0;
      err_drop_nx = 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (valid_in) err_drop_nx = 1'b1;
        end
        ST_WARMUP: begin
          if (valid_in) err_drop_nx = 1'b1;
          step_multi  = 1'b1;
          warm_cnt_nx = warm_cnt + 1'b1;
          if (warm_cnt == WARM_LAST) begin
            warm_cnt_nx = '0;
            if (e_lat == '0) begin
              done_nx  = 1'b1;
              state_nx = ST_IDLE;
            end else begin
              state_nx = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (valid_in) begin
            data_out_nx  = data_in ^ c;
            valid_out_nx = 1'b1;
            step_one     = 1'b1;
            bit_cnt_nx   = bit_cnt + E_ONE;
            if (bit_cnt == e_lat - E_ONE) begin
              done_nx  = 1'b1;
              state_nx = ST_IDLE;
            end
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pusch_scrambler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pusch_scrambler
//  Brief    : Self-checking bench for pusch_scrambler. Reference Gold sequence
//             is built from the recurrence definition; expected output bits
//             are queued when driven and compared when valid_out appears.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pusch_scrambler;

  localparam int E_WIDTH = 17;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [30:0]        c_init;
  logic [E_WIDTH-1:0] E;
  logic               data_in;
  logic               valid_in;
  logic               data_out;
  logic               valid_out;
  logic               ready;
  logic               done;
  logic               err_drop;

  typedef struct packed {
    logic d;
    logic dn;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   vcount = 0;
  int   dcount = 0;
  bit   gx1 [0:1759];
  bit   gx2 [0:1759];
  bit   cseq[0:127];

  always #5 clk = ~clk;

  pusch_scrambler #(
    .STEPS_PER_CYCLE (8),
    .E_WIDTH         (E_WIDTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .c_init    (c_init),
    .E         (E),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready     (ready),
    .done      (done),
    .err_drop  (err_drop)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, expv);
    end
  endtask

  // Reference c(n) = x1(n+1600) ^ x2(n+1600) from the array recurrences
  task automatic gen_c(input logic [30:0] ci);
    for (int n = 0; n < 31; n++) begin
      gx1[n] = (n == 0);
      gx2[n] = ci[n];
    end
    for (int n = 0; n + 31 < 1760; n++) begin
      gx1[n+31] = gx1[n+3] ^ gx1[n];
      gx2[n+31] = gx2[n+3] ^ gx2[n+2] ^ gx2[n+1] ^ gx2[n];
    end
    for (int i = 0; i < 128; i++) cseq[i] = gx1[i+1600] ^ gx2[i+1600];
  endtask

  // Output monitor: pops expected bits on every valid_out
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset) begin
      if (done) dcount++;
      if (valid_out) begin
        vcount++;
        if (exp_q.size() == 0) begin
          chk("unexpected_vout", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("data", {31'd0, data_out}, {31'd0, e.d});
          chk("done_tag", {31'd0, done}, {31'd0, e.dn});
        end
      end
    end
  end

  // Called at posedge+1; leaves the bench at posedge+1 of the first WARMUP cycle
  task automatic do_start(input logic [30:0] ci, input logic [E_WIDTH-1:0] e);
    start  = 1'b1;
    c_init = ci;
    E      = e;
    @(posedge clk); #1;
    start    = 1'b0;
    valid_in = 1'b0;
    c_init   = 31'($urandom);
    E        = E_WIDTH'($urandom);
    vcount   = 0;
    dcount   = 0;
    gen_c(ci);
  endtask

  task automatic wait_ready(input int exp_cycles);
    int cnt = 0;
    while (!ready && cnt < 1000) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("ready_latency", cnt, exp_cycles);
  endtask

  // mode 0: all zero, 1: all one, 2: random; gaps inserts an idle cycle between bits
  task automatic send_bits(input int n, input int mode, input bit gaps, input int elen);
    int   i = 0;
    int   j = 0;
    bit   d;
    exp_t ex;
    while (i < n) begin
      if (gaps && (j % 2 == 1)) begin
        valid_in = 1'b0;
      end else begin
        d        = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : 1'($urandom % 2);
        valid_in = 1'b1;
        data_in  = d;
        ex.d     = d ^ cseq[i];
        ex.dn    = (i == elen - 1);
        exp_q.push_back(ex);
        i++;
      end
      j++;
      @(posedge clk); #1;
    end
  endtask

  task automatic finish_cw(input int n);
    valid_in = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("queue_empty", exp_q.size(), 0);
    chk("vout_count", vcount, n);
    chk("done_count", dcount, 1);
    chk("idle_ready", {31'd0, ready}, 32'd0);
  endtask

  initial begin
    int cnt;
    reset    = 1'b1;
    start    = 1'b0;
    c_init   = '0;
    E        = '0;
    data_in  = 1'b0;
    valid_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {27'd0, data_out, valid_out, ready, done, err_drop}, 32'd0);
    reset = 1'b0;

    // c_init=0, all-zero data: output is c(0..31) itself
    do_start(31'd0, 17'd32);
    wait_ready(200);
    send_bits(32, 0, 1'b0, 32);
    finish_cw(32);

    // all-one data: output is ~c(i)
    do_start(31'h12345, 17'd100);
    wait_ready(200);
    send_bits(100, 1, 1'b0, 100);
    finish_cw(100);

    // gap-free and gapped runs against the same reference
    do_start(31'h55, 17'd50);
    wait_ready(200);
    send_bits(50, 2, 1'b0, 50);
    finish_cw(50);
    do_start(31'h55, 17'd50);
    wait_ready(200);
    send_bits(50, 2, 1'b1, 50);
    finish_cw(50);

    // valid_in during warm-up is dropped and flagged
    do_start(31'd5, 17'd10);
    repeat (10) begin
      @(posedge clk); #1;
    end
    valid_in = 1'b1;
    data_in  = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    chk("err_drop_set", {31'd0, err_drop}, 32'd1);
    chk("drop_no_vout", {31'd0, valid_out}, 32'd0);
    wait_ready(189);
    send_bits(10, 2, 1'b0, 10);
    finish_cw(10);
    chk("err_drop_sticky", {31'd0, err_drop}, 32'd1);
    do_start(31'h77, 17'd8);
    chk("err_drop_clear", {31'd0, err_drop}, 32'd0);
    wait_ready(200);
    send_bits(8, 2, 1'b0, 8);
    finish_cw(8);

    // restart after 20 of 64 bits, start coincident with a valid_in
    do_start(31'd7, 17'd64);
    wait_ready(200);
    send_bits(20, 2, 1'b0, 64);
    valid_in = 1'b1;
    data_in  = 1'b1;
    do_start(31'd9, 17'd40);
    chk("abort_vout", {31'd0, valid_out}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_err", {31'd0, err_drop}, 32'd0);
    wait_ready(200);
    send_bits(40, 2, 1'b0, 40);
    finish_cw(40);

    // reset mid-RUN clears outputs immediately
    do_start(31'd3, 17'd30);
    wait_ready(200);
    send_bits(5, 2, 1'b0, 30);
    valid_in = 1'b0;
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    chk("async_reset_outputs", {27'd0, data_out, valid_out, ready, done, err_drop}, 32'd0);
    chk("reset_queue_drained", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;

    // E=0: done one cycle after warm-up, never ready
    do_start(31'd11, 17'd0);
    cnt = 0;
    while (!done && cnt < 1000) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("e0_done_latency", cnt, 200);
    chk("e0_ready", {31'd0, ready}, 32'd0);
    @(posedge clk); #1;
    chk("e0_done_pulse", {31'd0, done}, 32'd0);
    chk("e0_done_count", dcount, 1);
    chk("e0_vout_count", vcount, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
